// File: rtl/dcim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcim_pkg
// Purpose  : Shared constants, width helper and state encoding for the
//            DCIM product accumulation path.
// Revision : 1.0 - initial release
// ============================================================================
package dcim_pkg;

    // Default product width coming out of the SRAM multiplier.
    localparam int c_PROD_WIDTH = 16;

    // Default group length: one full SRAM address sweep.
    localparam int c_GROUP_LEN  = 16;

    // Accumulator width large enough that a full group of maximum products
    // can never wrap.
    function automatic int acc_width(input int prod_width, input int group_len);
        return prod_width + $clog2(group_len);
    endfunction

    // Accumulator control states.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/dcim_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : dcim_result_fifo
// Purpose  : Small first-word-fall-through FIFO with a registered head.
//            A push into a full FIFO succeeds when a pop happens in the same
//            cycle; otherwise a push while full is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module dcim_result_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_CW = $clog2(DEPTH + 1);

    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_pop;
    logic             w_push;
    logic [c_CW-1:0]  w_wr_idx;

    // Entry 0 is always the head; entries shift towards it on a pop, so the
    // write slot is the current fill level minus any same-cycle pop.
    assign w_pop    = pop && (r_count != '0);
    assign w_push   = push && ((r_count != c_CW'(DEPTH)) || w_pop);
    assign w_wr_idx = r_count - c_CW'(w_pop);

    assign full  = (r_count == c_CW'(DEPTH));
    assign empty = (r_count == '0);
    assign dout  = r_mem[0];

    // Fill level tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            if (i < DEPTH - 1) begin : g_mid
                // Storage entry that can be written or refilled from above.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_mem[i] <= '0;
                    end else if (clear) begin
                        r_mem[i] <= '0;
                    end else if (w_push && (w_wr_idx == c_CW'(i))) begin
                        r_mem[i] <= din;
                    end else if (w_pop) begin
                        r_mem[i] <= r_mem[i+1];
                    end
                end
            end else begin : g_last
                // Tail entry; nothing above it to shift in.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_mem[i] <= '0;
                    end else if (clear) begin
                        r_mem[i] <= '0;
                    end else if (w_push && (w_wr_idx == c_CW'(i))) begin
                        r_mem[i] <= din;
                    end
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dcim_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : dcim_product_accumulator
// Purpose  : Sums each group of GROUP_LEN accepted products into one result
//            and queues results in a small FIFO. The upstream cannot be
//            stalled, so a result arriving at a full FIFO is dropped and
//            flagged with a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module dcim_product_accumulator
    import dcim_pkg::*;
#(
    parameter int PROD_WIDTH = c_PROD_WIDTH,
    parameter int GROUP_LEN  = c_GROUP_LEN,
    parameter int CNT_WIDTH  = $clog2(GROUP_LEN),
    parameter int ACC_WIDTH  = acc_width(PROD_WIDTH, GROUP_LEN),
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pe_ce,
    input  logic                  init_done,
    input  logic                  clear,
    input  logic                  prod_valid,
    input  logic [PROD_WIDTH-1:0] prod_data,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [CNT_WIDTH-1:0]  grp_idx,
    output logic                  busy,
    output logic                  drop_err
);

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_drop_err;

    logic                 w_accept;
    logic                 w_last;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;

    // A product counts only while running, enabled and upstream is in RUN.
    assign w_accept = (r_state == ACCUM) && pe_ce && init_done && prod_valid;
    assign w_last   = (r_cnt == CNT_WIDTH'(GROUP_LEN - 1));
    assign w_sum    = r_acc + ACC_WIDTH'(prod_data);

    // The closing product is folded into the pushed sum in the same cycle.
    assign w_push   = w_accept && w_last && !clear;
    assign w_pop    = res_valid && res_ready;
    assign w_drop   = w_push && w_full && !w_pop;

    assign res_valid = !w_empty;
    assign grp_idx   = r_cnt;
    assign busy      = (r_state == ACCUM);
    assign drop_err  = r_drop_err;

    // Group control, accumulation and sticky drop tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_drop_err <= 1'b0;
        end else if (clear) begin
            r_state    <= init_done ? ACCUM : IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
            if (pe_ce) begin
                case (r_state)
                    IDLE: begin
                        if (init_done) begin
                            r_state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (!init_done) begin
                            // Upstream left RUN: realign on the next group.
                            r_state <= IDLE;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                        end else if (prod_valid) begin
                            if (w_last) begin
                                r_acc <= '0;
                                r_cnt <= '0;
                            end else begin
                                r_acc <= w_sum;
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    dcim_result_fifo #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (w_push),
        .din   (w_sum),
        .pop   (w_pop),
        .dout  (res_data),
        .full  (w_full),
        .empty (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_dcim_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcim_product_accumulator
// Purpose  : Self-checking bench: a hand table, directed corner sequences
//            and random traffic compared against a queue-based group model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcim_product_accumulator;

    localparam int c_GL = 16;

    logic        clk;
    logic        rst_n;
    logic        pe_ce;
    logic        init_done;
    logic        clear;
    logic        prod_valid;
    logic [15:0] prod_data;
    logic [19:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  grp_idx;
    logic        busy;
    logic        drop_err;

    int total;
    int bad;

    // Reference model state: running flag, partial sum, products in group,
    // queue of finished sums, sticky drop.
    bit m_run;
    int m_acc;
    int m_cnt;
    int m_q[$];
    bit m_drop;

    dcim_product_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pe_ce      (pe_ce),
        .init_done  (init_done),
        .clear      (clear),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .grp_idx    (grp_idx),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        pe_ce;
        bit        init_done;
        bit        clear;
        bit        prod_valid;
        bit [15:0] prod_data;
        bit        res_ready;
        bit        exp_valid;
        bit [19:0] exp_data;
        bit [3:0]  exp_idx;
        bit        exp_busy;
        bit        exp_drop;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_acc  = 0;
        m_cnt  = 0;
        m_q.delete();
        m_drop = 0;
    endtask

    // Advance the model by one clock using the inputs presently driven.
    task automatic model_step();
        bit pop;
        bit push;
        int pushed;
        push   = 0;
        pushed = 0;
        if (clear) begin
            m_run = init_done;
            m_acc = 0;
            m_cnt = 0;
            m_q.delete();
            m_drop = 0;
            return;
        end
        pop = (m_q.size() > 0) && res_ready;
        if (pe_ce) begin
            if (!m_run) begin
                if (init_done) m_run = 1;
            end else if (!init_done) begin
                m_run = 0;
                m_acc = 0;
                m_cnt = 0;
            end else if (prod_valid) begin
                m_acc += int'(prod_data);
                m_cnt++;
                if (m_cnt == c_GL) begin
                    push   = 1;
                    pushed = m_acc;
                    m_acc  = 0;
                    m_cnt  = 0;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < 2) m_q.push_back(pushed);
            else m_drop = 1;
        end
    endtask

    task automatic model_compare();
        chk("res_valid", 32'(res_valid), 32'(m_q.size() > 0));
        chk("grp_idx", 32'(grp_idx), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_run));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        if (m_q.size() > 0) chk("res_data", 32'(res_data), 32'(m_q[0]));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        model_compare();
    endtask

    task automatic drive(input bit ce, input bit id, input bit clr,
                         input bit pv, input bit [15:0] pd, input bit rr);
        pe_ce      = ce;
        init_done  = id;
        clear      = clr;
        prod_valid = pv;
        prod_data  = pd;
        res_ready  = rr;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 16'h0, 1);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        int   pops;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1, 0, 0, 0, 16'h0, 1);
        model_reset();
        #12;

        // Reset state.
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_grp_idx", 32'(grp_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop_err", 32'(drop_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: ce, id, clr, pv, pd, rr -> valid, data, idx, busy, drop.
        vecs.push_back('{1,1,0,1,16'd9,1, 0,20'd0,4'd0,1,0}); // IDLE->ACCUM, product ignored
        vecs.push_back('{1,1,0,1,16'd5,1, 0,20'd0,4'd1,1,0});
        vecs.push_back('{1,1,0,1,16'd7,1, 0,20'd0,4'd2,1,0});
        vecs.push_back('{0,1,0,1,16'd9,1, 0,20'd0,4'd2,1,0}); // pe_ce low holds
        vecs.push_back('{1,1,0,0,16'd9,1, 0,20'd0,4'd2,1,0}); // no strobe
        vecs.push_back('{1,0,0,1,16'd9,1, 0,20'd0,4'd0,0,0}); // init_done drop
        vecs.push_back('{1,1,0,1,16'd9,1, 0,20'd0,4'd0,1,0}); // re-enter ACCUM
        vecs.push_back('{1,1,0,1,16'd3,1, 0,20'd0,4'd1,1,0});
        vecs.push_back('{1,1,1,1,16'd3,1, 0,20'd0,4'd0,1,0}); // clear with product
        vecs.push_back('{1,0,1,0,16'd0,1, 0,20'd0,4'd0,0,0}); // clear follows init_done
        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.pe_ce, v.init_done, v.clear, v.prod_valid, v.prod_data, v.res_ready);
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(res_valid), 32'(v.exp_valid));
            if (v.exp_valid) chk($sformatf("tbl%0d_data", i), 32'(res_data), 32'(v.exp_data));
            chk($sformatf("tbl%0d_idx", i), 32'(grp_idx), 32'(v.exp_idx));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(v.exp_busy));
            chk($sformatf("tbl%0d_drop", i), 32'(drop_err), 32'(v.exp_drop));
        end

        // 16 x 0xFFFF -> 0xFFFF0 right after the 16th edge.
        do_reset();
        drive(1, 1, 0, 0, 16'h0, 1);
        cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 1, 16'hFFFF, 1);
            cycle();
        end
        chk("max_valid", 32'(res_valid), 32'd1);
        chk("max_data", 32'(res_data), 32'hFFFF0);
        chk("max_drop", 32'(drop_err), 32'd0);
        drive(1, 1, 0, 0, 16'h0, 1);
        cycle();
        chk("max_popped", 32'(res_valid), 32'd0);

        // Products 1..32 back-to-back -> 136 then 392.
        for (int i = 1; i <= 32; i++) begin
            drive(1, 1, 0, 1, 16'(i), 1);
            cycle();
            if (i == 15) chk("wrap_idx15", 32'(grp_idx), 32'd15);
            if (i == 16) begin
                chk("g1_data", 32'(res_data), 32'd136);
                chk("g1_idx0", 32'(grp_idx), 32'd0);
            end
            if (i == 32) chk("g2_data", 32'(res_data), 32'd392);
        end

        // Three groups of 1 with consumer stalled: two kept, one dropped.
        drive(1, 1, 1, 0, 16'h0, 1);
        cycle();
        for (int i = 0; i < 48; i++) begin
            drive(1, 1, 0, 1, 16'd1, 0);
            cycle();
        end
        chk("ovr_drop", 32'(drop_err), 32'd1);
        chk("ovr_data", 32'(res_data), 32'd16);
        drive(1, 1, 0, 0, 16'h0, 1);
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid) pops++;
            cycle();
        end
        chk("ovr_pops", 32'(pops), 32'd2);
        chk("ovr_drop_sticky", 32'(drop_err), 32'd1);

        // Full FIFO, group completes on the same edge as a pop -> no drop.
        drive(1, 1, 1, 0, 16'h0, 0);
        cycle();
        for (int i = 0; i < 32; i++) begin
            drive(1, 1, 0, 1, 16'd1, 0);
            cycle();
        end
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 1, 16'd3, 0);
            cycle();
        end
        drive(1, 1, 0, 1, 16'd3, 1);
        cycle();
        chk("pp_drop", 32'(drop_err), 32'd0);
        chk("pp_head", 32'(res_data), 32'd16);
        drive(1, 1, 0, 0, 16'h0, 0);
        cycle();
        chk("pp_hold", 32'(res_data), 32'd16);
        drive(1, 1, 0, 0, 16'h0, 1);
        cycle();
        chk("pp_second", 32'(res_data), 32'd48);

        // Partial group discarded when init_done drops.
        drive(1, 1, 1, 0, 16'h0, 1);
        cycle();
        for (int i = 0; i < 7; i++) begin
            drive(1, 1, 0, 1, 16'd5, 1);
            cycle();
        end
        drive(1, 0, 0, 1, 16'd5, 1);
        cycle();
        chk("realign_idx", 32'(grp_idx), 32'd0);
        drive(1, 1, 0, 0, 16'h0, 1);
        cycle();
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 1, 16'd2, 1);
            cycle();
        end
        chk("realign_valid", 32'(res_valid), 32'd1);
        chk("realign_data", 32'(res_data), 32'd32);

        // Asynchronous reset between edges mid-group.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 1, 16'd4, 1);
            cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_idx", 32'(grp_idx), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_data", 32'(res_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1, 0, 0, 16'h0, 1);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1, 16'd6, 0);
            cycle();
        end
        drive(1, 1, 1, 1, 16'd6, 0);
        cycle();
        chk("clr_valid", 32'(res_valid), 32'd0);
        chk("clr_idx", 32'(grp_idx), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) != 0,
                  $urandom_range(0, 59) != 0,
                  $urandom_range(0, 299) == 0,
                  $urandom_range(0, 3) != 0,
                  16'($urandom),
                  $urandom_range(0, 3) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
